// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg
// Shared constants for the PS/2 mouse packet tracker:
//   - playfield bounds and the recenter/reset cursor position
//   - bit positions inside the PS/2 mouse header byte
//   - packet-assembly FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package mouse_pkg;

    // Playfield bounds (320x240) and cursor home position.
    localparam int unsigned X_MAX  = 319;
    localparam int unsigned Y_MAX  = 239;
    localparam int unsigned X_INIT = 160;
    localparam int unsigned Y_INIT = 120;

    // Header byte bit positions.
    localparam int BTN_L = 0;
    localparam int SYNC  = 3;   // always 1 in a genuine header byte
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Packet-assembly FSM encoding.
    localparam logic [1:0] WAIT_B0 = 2'd0;
    localparam logic [1:0] WAIT_B1 = 2'd1;
    localparam logic [1:0] WAIT_B2 = 2'd2;

endpackage

// File: rtl/axis_accum.sv
// ---------------------------------------------------------------------------
// axis_accum
// Saturating signed accumulate of one cursor axis: computes
// clamp(pos +/- delta, 0, MAX) in 11-bit signed so the intermediate sum
// can never wrap.
//   i_pos    9-bit unsigned current position
//   i_delta  9-bit two's-complement delta
//   i_sub    1 = pos - delta, 0 = pos + delta
//   o_pos    9-bit clamped result (combinational)
// ---------------------------------------------------------------------------
module axis_accum
    import mouse_pkg::*;
#(
    parameter int unsigned MAX = X_MAX
) (
    input  logic [8:0] i_pos,
    input  logic [8:0] i_delta,
    input  logic       i_sub,
    output logic [8:0] o_pos
);

    localparam logic signed [10:0] MAX_S = 11'(MAX);

    logic signed [10:0] w_pos_ext;
    logic signed [10:0] w_delta_ext;
    logic signed [10:0] w_sum;

    assign w_pos_ext   = $signed({2'b00, i_pos});
    assign w_delta_ext = $signed({{2{i_delta[8]}}, i_delta});
    assign w_sum       = i_sub ? (w_pos_ext - w_delta_ext) : (w_pos_ext + w_delta_ext);

    // NOTE: o_pos gets a default before the branches so every path assigns
    // it and no latch is inferred.
    always_comb begin
        o_pos = w_sum[8:0];
        if (w_sum < 11'sd0) begin
            o_pos = '0;
        end else if (w_sum > MAX_S) begin
            o_pos = MAX_S[8:0];
        end
    end

endmodule

// File: rtl/mouse_packet_tracker.sv
// ---------------------------------------------------------------------------
// mouse_packet_tracker
// Assembles 3-byte PS/2 mouse packets and accumulates the X/Y deltas into
// an absolute cursor position clamped to the 320x240 playfield.
//   CLOCK_50      system clock
//   resetn        asynchronous active-low reset
//   rx_data       received PS/2 byte
//   rx_valid      one-cycle strobe, rx_data valid
//   recenter      move cursor to (X_INIT, Y_INIT) on the next edge
//   x, y          cursor position (y = 0 is the top row)
//   left_click    left button level from the last accepted packet
//   click_pulse   one cycle on a left-button 0->1 between packets
//   packet_valid  one cycle when a packet is applied
//   sync_err      one cycle on a rejected header byte or a timeout
// ---------------------------------------------------------------------------
module mouse_packet_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       recenter,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       left_click,
    output logic       click_pulse,
    output logic       packet_valid,
    output logic       sync_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_state;
    logic          r_hdr_left;
    logic          r_hdr_xsign;
    logic          r_hdr_ysign;
    logic          r_hdr_xovf;
    logic          r_hdr_yovf;
    logic [7:0]    r_dx;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_x;
    logic [8:0]    r_y;
    logic          r_left;
    logic          r_click;
    logic          r_pkt;
    logic          r_serr;

    logic [8:0]    w_dx;
    logic [8:0]    w_dy;
    logic [8:0]    w_x_new;
    logic [8:0]    w_y_new;
    logic          w_timeout;

    // An overflowed axis contributes nothing; the third byte (dy) is used
    // straight off rx_data on the apply cycle.
    assign w_dx      = r_hdr_xovf ? 9'd0 : {r_hdr_xsign, r_dx};
    assign w_dy      = r_hdr_yovf ? 9'd0 : {r_hdr_ysign, rx_data};
    assign w_timeout = !rx_valid && (r_cnt == CNT_LAST);

    axis_accum #(.MAX(X_MAX)) u_x_accum (
        .i_pos   (r_x),
        .i_delta (w_dx),
        .i_sub   (1'b0),
        .o_pos   (w_x_new)
    );

    // PS/2 reports up as positive, the screen counts rows downwards.
    axis_accum #(.MAX(Y_MAX)) u_y_accum (
        .i_pos   (r_y),
        .i_delta (w_dy),
        .i_sub   (1'b1),
        .o_pos   (w_y_new)
    );

    // NOTE: all state here is sequential, so it uses non-blocking assignments
    // only; later assignments in the block (recenter) override earlier ones.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= WAIT_B0;
            r_hdr_left  <= 1'b0;
            r_hdr_xsign <= 1'b0;
            r_hdr_ysign <= 1'b0;
            r_hdr_xovf  <= 1'b0;
            r_hdr_yovf  <= 1'b0;
            r_dx        <= '0;
            r_cnt       <= '0;
            r_x         <= 9'(X_INIT);
            r_y         <= 9'(Y_INIT);
            r_left      <= 1'b0;
            r_click     <= 1'b0;
            r_pkt       <= 1'b0;
            r_serr      <= 1'b0;
        end else begin
            r_click <= 1'b0;
            r_pkt   <= 1'b0;
            r_serr  <= 1'b0;

            case (r_state)
                WAIT_B0: begin
                    r_cnt <= '0;
                    if (rx_valid) begin
                        if (rx_data[SYNC]) begin
                            r_hdr_left  <= rx_data[BTN_L];
                            r_hdr_xsign <= rx_data[XSIGN];
                            r_hdr_ysign <= rx_data[YSIGN];
                            r_hdr_xovf  <= rx_data[XOVF];
                            r_hdr_yovf  <= rx_data[YOVF];
                            r_state     <= WAIT_B1;
                        end else begin
                            r_serr <= 1'b1;
                        end
                    end
                end

                WAIT_B1: begin
                    if (rx_valid) begin
                        r_dx    <= rx_data;
                        r_cnt   <= '0;
                        r_state <= WAIT_B2;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_serr  <= 1'b1;
                        r_state <= WAIT_B0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                WAIT_B2: begin
                    if (rx_valid) begin
                        r_x     <= w_x_new;
                        r_y     <= w_y_new;
                        r_left  <= r_hdr_left;
                        r_click <= r_hdr_left & ~r_left;
                        r_pkt   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= WAIT_B0;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_serr  <= 1'b1;
                        r_state <= WAIT_B0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_B0;
                end
            endcase

            // Recenter wins over a coincident packet for position only.
            if (recenter) begin
                r_x <= 9'(X_INIT);
                r_y <= 9'(Y_INIT);
            end
        end
    end

    assign x            = r_x;
    assign y            = r_y;
    assign left_click   = r_left;
    assign click_pulse  = r_click;
    assign packet_valid = r_pkt;
    assign sync_err     = r_serr;

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// ---------------------------------------------------------------------------
// tb_mouse_packet_tracker
// Directed self-checking bench: a table of packets with hand-computed
// cursor results, followed by hand-written sequences for the bad header,
// timeouts and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_mouse_packet_tracker;

    localparam int unsigned T_TB = 50;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       recenter;
    logic [8:0] x;
    logic [8:0] y;
    logic       left_click;
    logic       click_pulse;
    logic       packet_valid;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;
    int serr_cnt = 0;
    int pkt_cnt  = 0;

    mouse_packet_tracker #(.TIMEOUT_CYCLES(T_TB)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .recenter     (recenter),
        .x            (x),
        .y            (y),
        .left_click   (left_click),
        .click_pulse  (click_pulse),
        .packet_valid (packet_valid),
        .sync_err     (sync_err)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Count high cycles of each status strobe; a stretched pulse counts twice.
    always @(negedge CLOCK_50) begin
        if (sync_err)     serr_cnt++;
        if (packet_valid) pkt_cnt++;
    end

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       rc;
        logic [8:0] ex;
        logic [8:0] ey;
        logic       el;
        logic       ec;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Three back-to-back bytes; returns just after the apply edge.
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic rc);
        rx_valid = 1'b1;
        rx_data  = b0;
        tick();
        rx_data  = b1;
        tick();
        rx_data  = b2;
        recenter = rc;
        tick();
        rx_valid = 1'b0;
        recenter = 1'b0;
    endtask

    initial begin
        int s0;
        int p0;

        vecs[0]  = '{8'h08, 8'h0A, 8'h05, 1'b0, 9'd170, 9'd115, 1'b0, 1'b0};
        vecs[1]  = '{8'h19, 8'hF6, 8'h00, 1'b0, 9'd160, 9'd115, 1'b1, 1'b1};
        vecs[2]  = '{8'h19, 8'hF6, 8'h00, 1'b0, 9'd150, 9'd115, 1'b1, 1'b0};
        vecs[3]  = '{8'h08, 8'h00, 8'h00, 1'b0, 9'd150, 9'd115, 1'b0, 1'b0};
        vecs[4]  = '{8'h18, 8'h6F, 8'h00, 1'b0, 9'd5,   9'd115, 1'b0, 1'b0};
        vecs[5]  = '{8'h18, 8'h80, 8'h00, 1'b0, 9'd0,   9'd115, 1'b0, 1'b0};
        vecs[6]  = '{8'h08, 8'hFF, 8'h00, 1'b0, 9'd255, 9'd115, 1'b0, 1'b0};
        vecs[7]  = '{8'h08, 8'h2D, 8'h00, 1'b0, 9'd300, 9'd115, 1'b0, 1'b0};
        vecs[8]  = '{8'h08, 8'h7F, 8'h00, 1'b0, 9'd319, 9'd115, 1'b0, 1'b0};
        vecs[9]  = '{8'h08, 8'h00, 8'h71, 1'b0, 9'd319, 9'd2,   1'b0, 1'b0};
        vecs[10] = '{8'h08, 8'h00, 8'h05, 1'b0, 9'd319, 9'd0,   1'b0, 1'b0};
        vecs[11] = '{8'h28, 8'h00, 8'h00, 1'b0, 9'd319, 9'd239, 1'b0, 1'b0};
        vecs[12] = '{8'h48, 8'h50, 8'h03, 1'b0, 9'd319, 9'd236, 1'b0, 1'b0};
        vecs[13] = '{8'h88, 8'h00, 8'h50, 1'b0, 9'd319, 9'd236, 1'b0, 1'b0};
        vecs[14] = '{8'h09, 8'h20, 8'h20, 1'b1, 9'd160, 9'd120, 1'b1, 1'b1};
        vecs[15] = '{8'h08, 8'h02, 8'h00, 1'b0, 9'd162, 9'd120, 1'b0, 1'b0};

        resetn   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        recenter = 1'b0;
        tick();
        tick();
        check("reset_x", int'(x), 160);
        check("reset_y", int'(y), 120);
        check("reset_left", int'(left_click), 0);
        check("reset_click", int'(click_pulse), 0);
        check("reset_pv", int'(packet_valid), 0);
        check("reset_serr", int'(sync_err), 0);
        resetn = 1'b1;
        tick();

        // Table of packets, each applied back-to-back.
        for (int i = 0; i < NV; i++) begin
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].rc);
            check($sformatf("v%0d_x", i), int'(x), int'(vecs[i].ex));
            check($sformatf("v%0d_y", i), int'(y), int'(vecs[i].ey));
            check($sformatf("v%0d_left", i), int'(left_click), int'(vecs[i].el));
            check($sformatf("v%0d_click", i), int'(click_pulse), int'(vecs[i].ec));
            check($sformatf("v%0d_pv", i), int'(packet_valid), 1);
            tick();
            check($sformatf("v%0d_pv_off", i), int'(packet_valid), 0);
            check($sformatf("v%0d_click_off", i), int'(click_pulse), 0);
        end
        check("table_pv_count", pkt_cnt, NV);
        check("table_serr_count", serr_cnt, 0);

        // Bad header byte in WAIT_B0.
        send_byte(8'h00);
        check("badhdr_serr", int'(sync_err), 1);
        check("badhdr_pv", int'(packet_valid), 0);
        check("badhdr_x", int'(x), 162);
        tick();
        check("badhdr_serr_off", int'(sync_err), 0);

        // Timeout in WAIT_B1.
        s0 = serr_cnt;
        p0 = pkt_cnt;
        send_byte(8'h08);
        for (int i = 0; i < int'(T_TB) - 2; i++) tick();
        check("to_b1_not_early", serr_cnt, s0);
        for (int i = 0; i < 10; i++) tick();
        check("to_b1_serr", serr_cnt, s0 + 1);

        // Timeout in WAIT_B2.
        s0 = serr_cnt;
        rx_valid = 1'b1;
        rx_data  = 8'h08;
        tick();
        send_byte(8'h01);
        for (int i = 0; i < int'(T_TB) - 2; i++) tick();
        check("to_b2_not_early", serr_cnt, s0);
        for (int i = 0; i < 10; i++) tick();
        check("to_b2_serr", serr_cnt, s0 + 1);
        check("to_no_apply", pkt_cnt, p0);
        check("to_x_hold", int'(x), 162);

        // Fresh packet after the timeouts.
        send_packet(8'h08, 8'h02, 8'h00, 1'b0);
        check("post_to_x", int'(x), 164);
        check("post_to_y", int'(y), 120);
        check("post_to_pv", int'(packet_valid), 1);
        tick();

        // Reset between bytes 1 and 2.
        send_byte(8'h09);
        resetn = 1'b0;
        #2;
        check("midrst_x", int'(x), 160);
        check("midrst_y", int'(y), 120);
        check("midrst_left", int'(left_click), 0);
        check("midrst_pv", int'(packet_valid), 0);
        check("midrst_click", int'(click_pulse), 0);
        check("midrst_serr", int'(sync_err), 0);
        tick();
        resetn = 1'b1;
        tick();
        send_packet(8'h08, 8'h0A, 8'h05, 1'b0);
        check("after_rst_x", int'(x), 170);
        check("after_rst_y", int'(y), 115);
        check("after_rst_left", int'(left_click), 0);
        check("after_rst_pv", int'(packet_valid), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_packet_tracker.md
Name: mouse_packet_tracker

Overview:
- Sits between the PS/2 byte receiver and the cursor/VGA stage.
- Assembles standard 3-byte PS/2 mouse packets and accumulates the signed X/Y deltas into absolute 9-bit screen coordinates, clamped to the 320x240 playfield.
- Exposes left-button level, a one-cycle click pulse and status strobes for the game logic.
- Its x/y outputs feed the cursor renderer directly.

Parameters:
- X_MAX, 319, largest legal x coordinate
- Y_MAX, 239, largest legal y coordinate
- X_INIT, 160, x after reset or recenter
- Y_INIT, 120, y after reset or recenter
- TIMEOUT_CYCLES, 100000, idle cycles mid-packet before resync (2 ms at 50 MHz)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- rx_data  in  8  received PS/2 byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- recenter  in  1  synchronous request to move cursor to (X_INIT, Y_INIT)
- x  out  9  cursor x, 0..X_MAX
- y  out  9  cursor y, 0..Y_MAX, 0 = top row
- left_click  out  1  left button level from last accepted packet
- click_pulse  out  1  one cycle on left-button 0->1 between accepted packets
- packet_valid  out  1  one cycle when a packet is applied
- sync_err  out  1  one cycle on a rejected header byte or timeout

Behaviour:
- Reset values (async, resetn=0):
  - x=X_INIT, y=Y_INIT
  - left_click=0, click_pulse=0, packet_valid=0, sync_err=0
  - FSM in WAIT_B0, timeout counter=0
- FSM states:
  - WAIT_B0: on rx_valid with rx_data[3]=1, latch byte as header -> WAIT_B1. On rx_valid with rx_data[3]=0, discard byte, pulse sync_err next cycle, stay in WAIT_B0.
  - WAIT_B1: on rx_valid, latch dx byte -> WAIT_B2.
  - WAIT_B2: on rx_valid, apply the packet -> WAIT_B0.
- Timeout:
  - Counter clears on every rx_valid and whenever the FSM is in WAIT_B0.
  - In WAIT_B1/WAIT_B2, reaching TIMEOUT_CYCLES-1 idle cycles returns the FSM to WAIT_B0, drops the partial packet and pulses sync_err.
- Header bit use: bit0 = left button, bit4 = X sign, bit5 = Y sign, bit6 = X overflow, bit7 = Y overflow.
- Delta arithmetic:
  - dx = {hdr[4], byte1} and dy = {hdr[5], byte2}, each 9-bit two's complement, sign-extended to 11 bits.
  - If the overflow bit is set for an axis, that axis delta is treated as 0.
- Position update:
  - x_new = clamp(x + dx, 0, X_MAX).
  - y_new = clamp(y - dy, 0, Y_MAX); PS/2 up is positive, screen down is positive.
  - All sums are computed in 11-bit signed to avoid wrap; a negative result clamps to 0, a result above MAX clamps to MAX.
- Latency:
  - x, y, left_click and packet_valid update on the clock edge that samples the third byte's rx_valid, so they are visible the cycle after the rx_valid cycle.
  - click_pulse is asserted in that same cycle when the new left bit is 1 and the previous left_click was 0.
- recenter:
  - Sets x=X_INIT, y=Y_INIT on the next edge. Does not affect the FSM or the buttons.
  - If it coincides with a packet apply, recenter wins for x/y; left_click, click_pulse and packet_valid still follow the packet.
- rx_valid held high on consecutive cycles is treated as consecutive bytes.
- Status pulses are never wider than one cycle.
- resetn asserted mid-packet aborts the packet; no partial update leaks out.

Decomposition:
- Shared package mouse_pkg holds:
  - screen bound constants (X_MAX, Y_MAX, X_INIT, Y_INIT)
  - header bit index constants (BTN_L, XSIGN, YSIGN, XOVF, YOVF, SYNC)
  - the FSM state encoding
- One sub-module, axis_accum: saturating signed accumulate of a 9-bit position and a 9-bit two's-complement delta with a subtract select. Instantiated once for x (add) and once for y (subtract).

Test Plan:
- Reset, then bytes 0x08,0x0A,0x05 -> x=170, y=115, left_click=0, packet_valid single pulse one cycle after the third rx_valid.
- Bytes 0x19,0xF6,0x00, where 0x19 sets bits 3, 4 and 0 (dx=-10, left) -> x decreases by 10, left_click=1, click_pulse single pulse. A repeated identical packet gives no second click_pulse.
- From x=5, bytes 0x18,0x80,0x00 (dx=-128) -> x=0. From x=300, bytes 0x08,0x7F,0x00 -> x=319. From y=2, bytes 0x08,0x00,0x05 -> y=0.
- Header 0x48 (X overflow) with dx 0x50, dy 0x03 -> x unchanged, y decreases by 3.
- Byte 0x00 in WAIT_B0 -> sync_err pulse, no update. Then 0x08,0x01, stall 100000 cycles -> sync_err pulse, FSM in WAIT_B0. The next three bytes 0x08,0x02,0x00 apply as a fresh packet: x=+2.
- recenter asserted the same cycle as the third byte of 0x09,0x20,0x20 -> x=160, y=120, left_click=1, click_pulse=1. resetn pulsed between bytes 1 and 2 -> all outputs at their reset values, and the following bytes are parsed from WAIT_B0.
